id_ex_stage_register: RTL

ID/EX pipeline register for the 5-stage MIPS32 core. It captures decode-stage operands, register specifiers and control into the EX stage, and detects load-use hazards. On a load-use hazard it stalls the front end and inserts a bubble, and on branch flush it squashes the instruction. Its registered outputs feed the EX-stage forwarding muxes and the forwarding unit directly.

---
 rtl/mips_pipe_pkg.sv | 43 ++++
 rtl/load_use_detect.sv | 19 +
 rtl/id_ex_stage_register.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control bundle layout, bubble constant,
// forward-select encodings and the ID/EX datapath payload.
package mips_pipe_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CTRL_W = 9;

   // Control bundle bit positions
   localparam int unsigned CTRL_REGWRITE = 8;
   localparam int unsigned CTRL_MEMTOREG = 7;
   localparam int unsigned CTRL_MEMREAD  = 6;
   localparam int unsigned CTRL_MEMWRITE = 5;
   localparam int unsigned CTRL_ALUSRC   = 4;
   localparam int unsigned CTRL_REGDST   = 3;
   localparam int unsigned CTRL_BRANCH   = 2;
   localparam int unsigned CTRL_ALUOP_HI = 1;
   localparam int unsigned CTRL_ALUOP_LO = 0;

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   typedef enum logic [1:0] {
      FWD_ID  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic [XLEN-1:0]   read_data_1;
      logic [XLEN-1:0]   read_data_2;
      logic [XLEN-1:0]   sign_extend;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
   } id_ex_data_t;

   // Register 0 is hardwired, so it never matches anything.
   function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection producing the front-end stall.
module load_use_detect
   import mips_pipe_pkg::*;
(
   input  logic              valid_ex,
   input  logic              mem_read_ex,
   input  logic [REG_AW-1:0] rt_ex,
   input  logic [REG_AW-1:0] rs_id,
   input  logic [REG_AW-1:0] rt_id,
   input  logic              hold,
   output logic              load_use_c,
   output logic              stall_c
);

   assign load_use_c = valid_ex & mem_read_ex &
                       (reg_match(rt_ex, rs_id) | reg_match(rt_ex, rt_id));
   assign stall_c    = load_use_c | hold;

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional WB write-through on capture: define ID_EX_WB_BYPASS_EN.
module id_ex_stage_register #(
   parameter int unsigned CTRL_W = mips_pipe_pkg::CTRL_W
) (
   input  logic                                Clk,
   input  logic                                Reset_n,
   input  logic [mips_pipe_pkg::XLEN-1:0]      Read_Data_1_ID,
   input  logic [mips_pipe_pkg::XLEN-1:0]      Read_Data_2_ID,
   input  logic [mips_pipe_pkg::XLEN-1:0]      Sign_Extend_ID,
   input  logic [mips_pipe_pkg::REG_AW-1:0]    Rs_ID,
   input  logic [mips_pipe_pkg::REG_AW-1:0]    Rt_ID,
   input  logic [mips_pipe_pkg::REG_AW-1:0]    Rd_ID,
   input  logic [CTRL_W-1:0]                   Control_ID,
   input  logic                                Flush_EX,
   input  logic                                Hold_EX,
   input  logic                                Reg_Write_WB,
   input  logic [mips_pipe_pkg::REG_AW-1:0]    Write_Register_WB,
   input  logic [mips_pipe_pkg::XLEN-1:0]      Write_Data_WB,
   output logic [mips_pipe_pkg::XLEN-1:0]      Read_Data_1_EX,
   output logic [mips_pipe_pkg::XLEN-1:0]      Read_Data_2_EX,
   output logic [mips_pipe_pkg::XLEN-1:0]      Sign_Extend_EX,
   output logic [mips_pipe_pkg::REG_AW-1:0]    Rs_EX,
   output logic [mips_pipe_pkg::REG_AW-1:0]    Rt_EX,
   output logic [mips_pipe_pkg::REG_AW-1:0]    Rd_EX,
   output logic [CTRL_W-1:0]                   Control_EX,
   output logic                                Valid_EX,
   output logic                                Stall_ID
);

   import mips_pipe_pkg::*;

   id_ex_data_t       data_q, data_d, data_cap;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic              load_use_c;

   load_use_detect u_load_use_detect (
      .valid_ex    (valid_q),
      .mem_read_ex (ctrl_q[CTRL_MEMREAD]),
      .rt_ex       (data_q.rt),
      .rs_id       (Rs_ID),
      .rt_id       (Rt_ID),
      .hold        (Hold_EX),
      .load_use_c  (load_use_c),
      .stall_c     (Stall_ID)
   );

   // Operand capture, optionally taking the value being written back this cycle
   always_comb begin
      data_cap             = '0;
      data_cap.read_data_1 = Read_Data_1_ID;
      data_cap.read_data_2 = Read_Data_2_ID;
      data_cap.sign_extend = Sign_Extend_ID;
      data_cap.rs          = Rs_ID;
      data_cap.rt          = Rt_ID;
      data_cap.rd          = Rd_ID;
`ifdef ID_EX_WB_BYPASS_EN
      if (Reg_Write_WB && reg_match(Write_Register_WB, Rs_ID))
         data_cap.read_data_1 = Write_Data_WB;
      if (Reg_Write_WB && reg_match(Write_Register_WB, Rt_ID))
         data_cap.read_data_2 = Write_Data_WB;
`endif
   end

`ifndef ID_EX_WB_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^{Reg_Write_WB, Write_Register_WB, Write_Data_WB};
`endif

   // Update priority: flush, hold, load-use bubble, normal capture
   always_comb begin
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      if (Flush_EX) begin
         data_d  = '0;
         ctrl_d  = CTRL_W'(CTRL_NOP);
         valid_d = 1'b0;
      end else if (Hold_EX) begin
         data_d  = data_q;
      end else if (load_use_c) begin
         data_d  = '0;
         ctrl_d  = CTRL_W'(CTRL_NOP);
         valid_d = 1'b0;
      end else begin
         data_d  = data_cap;
         ctrl_d  = Control_ID;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         data_q  <= '0;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   assign Read_Data_1_EX = data_q.read_data_1;
   assign Read_Data_2_EX = data_q.read_data_2;
   assign Sign_Extend_EX = data_q.sign_extend;
   assign Rs_EX          = data_q.rs;
   assign Rt_EX          = data_q.rt;
   assign Rd_EX          = data_q.rd;
   assign Control_EX     = ctrl_q;
   assign Valid_EX       = valid_q;

endmodule
